// File: rtl/psum_accum_drain.sv
// Partial-sum accumulator: sums PE output vectors across input-channel passes, then drains
// saturated elements one per beat over valid/ready. Optional macro PSUM_RELU_EN clamps negatives to 0.
module psum_accum_drain #(
   parameter int NUM_OUT = 96,
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 24,
   parameter int PASS_W  = 4,
   localparam int IDX_W  = $clog2(NUM_OUT)
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_start,
   input  logic [PASS_W-1:0]          i_num_pass,
   input  logic                       i_pe_finish,
   input  logic [DATA_W*NUM_OUT-1:0]  i_pe_feature,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [DATA_W-1:0]          o_data,
   output logic [IDX_W-1:0]           o_idx,
   output logic                       o_last,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_overrun
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACC   = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   // One guard bit is enough: the sum of two ACC_W-range values fits in ACC_W+1 bits.
   function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] v);
      logic [ACC_W-1:0] r;
      if (v[ACC_W] != v[ACC_W-1]) begin
         r = v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         r = v[ACC_W-1:0];
      end
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] drain_val(input logic [ACC_W-1:0] a);
      logic [DATA_W-1:0] r;
      if ((&a[ACC_W-1:DATA_W-1]) || !(|a[ACC_W-1:DATA_W-1])) begin
         r = a[DATA_W-1:0];
      end else begin
         r = a[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end
`ifdef PSUM_RELU_EN
      if (r[DATA_W-1]) begin
         r = {DATA_W{1'b0}};
      end else begin
         r = r;
      end
`endif
      return r;
   endfunction

   state_e                 state_q, state_d;
   logic [ACC_W-1:0]       acc_q [NUM_OUT];
   logic [ACC_W-1:0]       acc_d [NUM_OUT];
   logic [PASS_W-1:0]      pass_cnt_q, pass_cnt_d;
   logic [PASS_W-1:0]      num_pass_q, num_pass_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [IDX_W-1:0]       idx_inc;
   logic                   valid_q, valid_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   last_q, last_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   overrun_q, overrun_d;

   assign idx_inc = idx_q + IDX_W'(1);

   // Next-state, accumulate and drain-beat computation; beat outputs are prepared one cycle ahead.
   always_comb begin
      state_d    = state_q;
      pass_cnt_d = pass_cnt_q;
      num_pass_d = num_pass_q;
      idx_d      = idx_q;
      valid_d    = valid_q;
      data_d     = data_q;
      last_d     = last_q;
      done_d     = 1'b0;
      overrun_d  = overrun_q;
      for (int k = 0; k < NUM_OUT; k++) begin
         acc_d[k] = acc_q[k];
      end

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               for (int k = 0; k < NUM_OUT; k++) begin
                  acc_d[k] = {ACC_W{1'b0}};
               end
               pass_cnt_d = {PASS_W{1'b0}};
               num_pass_d = (i_num_pass == {PASS_W{1'b0}}) ? PASS_W'(1) : i_num_pass;
               overrun_d  = 1'b0;
               state_d    = S_ACC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACC: begin
            if (i_pe_finish) begin
               for (int k = 0; k < NUM_OUT; k++) begin
                  acc_d[k] = sat_acc({acc_q[k][ACC_W-1], acc_q[k]} +
                                     {{(ACC_W+1-DATA_W){i_pe_feature[k*DATA_W+DATA_W-1]}},
                                      i_pe_feature[k*DATA_W +: DATA_W]});
               end
               pass_cnt_d = pass_cnt_q + PASS_W'(1);
               if ((pass_cnt_q + PASS_W'(1)) == num_pass_q) begin
                  state_d = S_DRAIN;
                  idx_d   = {IDX_W{1'b0}};
                  valid_d = 1'b1;
                  data_d  = drain_val(acc_d[0]);
                  last_d  = (NUM_OUT == 1);
               end else begin
                  state_d = S_ACC;
               end
            end else begin
               state_d = S_ACC;
            end
         end
         S_DRAIN: begin
            if (valid_q && i_ready) begin
               if (last_q) begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d  = idx_inc;
                  data_d = drain_val(acc_q[idx_inc]);
                  last_d = (idx_inc == IDX_W'(NUM_OUT-1));
               end
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase

      // A stray pulse wins over the clear from a same-cycle start.
      if (i_pe_finish && (state_q != S_ACC)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_d;
      end
      busy_d = (state_d != S_IDLE);
   end

   // State, accumulator and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         pass_cnt_q <= {PASS_W{1'b0}};
         num_pass_q <= {PASS_W{1'b0}};
         idx_q      <= {IDX_W{1'b0}};
         valid_q    <= 1'b0;
         data_q     <= {DATA_W{1'b0}};
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
         for (int k = 0; k < NUM_OUT; k++) begin
            acc_q[k] <= {ACC_W{1'b0}};
         end
      end else begin
         state_q    <= state_d;
         pass_cnt_q <= pass_cnt_d;
         num_pass_q <= num_pass_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         last_q     <= last_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         overrun_q  <= overrun_d;
         for (int k = 0; k < NUM_OUT; k++) begin
            acc_q[k] <= acc_d[k];
         end
      end
   end

   assign o_valid   = valid_q;
   assign o_data    = data_q;
   assign o_idx     = idx_q;
   assign o_last    = last_q;
   assign o_busy    = busy_q;
   assign o_done    = done_q;
   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_psum_accum_drain.sv
// Scoreboard bench for psum_accum_drain: stimulus pushes expected beats, a negedge monitor checks them.
module tb_psum_accum_drain;
   localparam int N  = 96;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            i_start = 1'b0;
   logic [3:0]      i_num_pass = 4'd0;
   logic            i_pe_finish = 1'b0;
   logic [DW*N-1:0] feat = '0;
   logic            i_ready = 1'b0;
   logic            o_valid, o_last, o_busy, o_done, o_overrun;
   logic [DW-1:0]   o_data;
   logic [6:0]      o_idx;

   typedef struct {int d; int idx; int last;} beat_t;
   beat_t sb[$];
   int    exp_acc[N];
   int    n_checks = 0;
   int    n_pass = 0;

   psum_accum_drain dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_num_pass(i_num_pass),
      .i_pe_finish(i_pe_finish), .i_pe_feature(feat), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_idx(o_idx), .o_last(o_last), .o_busy(o_busy), .o_done(o_done),
      .o_overrun(o_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic int exp_val(input int a);
      int r;
      r = (a > 32767) ? 32767 : ((a < -32768) ? -32768 : a);
`ifdef PSUM_RELU_EN
      if (r < 0) r = 0;
`endif
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_feat(input int base, input int step);
      for (int k = 0; k < N; k++) feat[k*DW +: DW] = 16'(base + step*k);
   endtask

   task automatic push_tile();
      beat_t b;
      for (int k = 0; k < N; k++) begin
         b.d = exp_val(exp_acc[k]); b.idx = k; b.last = (k == N-1) ? 1 : 0;
         sb.push_back(b);
      end
   endtask

   task automatic start_tile(input int np);
      i_start = 1'b1; i_num_pass = 4'(np);
      cyc();
      i_start = 1'b0;
   endtask

   task automatic pulse();
      i_pe_finish = 1'b1;
      cyc();
      i_pe_finish = 1'b0;
   endtask

   task automatic wait_done(input bit tog);
      int got = 0;
      for (int c = 0; c < 1000 && got == 0; c++) begin
         if (tog) i_ready = ~i_ready;
         cyc();
         if (o_done) got = 1;
      end
      chk("done_seen", got, 1);
      chk("sb_drained", sb.size(), 0);
      chk("idle_after_done", int'(o_busy), 0);
   endtask

   // Monitor: every presented beat must match the scoreboard head; pop on acceptance.
   always @(negedge clk) begin
      if (rst_n && o_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_beat", int'(o_idx), -1);
         end else begin
            chk("beat_data", int'($signed(o_data)), sb[0].d);
            chk("beat_idx", int'(o_idx), sb[0].idx);
            chk("beat_last", int'(o_last), sb[0].last);
            if (i_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      int found;
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_done", int'(o_done), 0);
      chk("rst_overrun", int'(o_overrun), 0);
      chk("rst_data", int'(o_data), 0);
      chk("rst_idx", int'(o_idx), 0);
      chk("rst_last", int'(o_last), 0);

      // single pass, ramp k-48
      set_feat(-48, 1);
      for (int k = 0; k < N; k++) exp_acc[k] = k - 48;
      i_ready = 1'b1;
      start_tile(1);
      chk("busy_in_acc", int'(o_busy), 1);
      push_tile();
      pulse();
      wait_done(1'b0);

      // three passes of 20000 saturate on drain
      set_feat(20000, 0);
      for (int k = 0; k < N; k++) exp_acc[k] = 60000;
      start_tile(3);
      push_tile();
      pulse(); pulse(); pulse();
      wait_done(1'b0);

      // two passes with toggled ready; negative end saturates low
      set_feat(-20000, 300);
      for (int k = 0; k < N; k++) exp_acc[k] = 2 * (300*k - 20000);
      i_ready = 1'b0;
      start_tile(2);
      push_tile();
      pulse(); pulse();
      wait_done(1'b1);

      // overrun from idle, then ignored start and pulse during drain
      i_ready = 1'b1;
      pulse();
      chk("overrun_idle", int'(o_overrun), 1);
      set_feat(100, -1);
      for (int k = 0; k < N; k++) exp_acc[k] = 100 - k;
      start_tile(1);
      chk("overrun_cleared", int'(o_overrun), 0);
      push_tile();
      i_ready = 1'b0;
      pulse();
      chk("drain_latency", int'(o_valid), 1);
      start_tile(1);
      set_feat(0, 0);
      pulse();
      chk("overrun_drain", int'(o_overrun), 1);
      chk("busy_drain", int'(o_busy), 1);
      i_ready = 1'b1;
      wait_done(1'b0);
      cyc(); cyc();
      chk("start_ignored", int'(o_busy), 0);
      chk("overrun_sticky", int'(o_overrun), 1);

      // reset at beat 40
      set_feat(0, 7);
      for (int k = 0; k < N; k++) exp_acc[k] = 7*k;
      start_tile(1);
      push_tile();
      pulse();
      found = 0;
      for (int c = 0; c < 200; c++) begin
         if (o_valid && o_idx == 7'd40) begin
            found = 1;
            break;
         end
         cyc();
      end
      chk("reach_idx40", found, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", int'(o_valid), 0);
      chk("rst_mid_busy", int'(o_busy), 0);
      chk("beats_before_rst", sb.size(), N - 40);
      sb.delete();
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
      chk("post_rst_valid", int'(o_valid), 0);
      set_feat(-48, 1);
      for (int k = 0; k < N; k++) exp_acc[k] = k - 48;
      start_tile(1);
      push_tile();
      pulse();
      wait_done(1'b0);

      // num_pass=0 with a same-cycle stray pulse in idle
      set_feat(-100, 3);
      for (int k = 0; k < N; k++) exp_acc[k] = 3*k - 100;
      i_start = 1'b1; i_num_pass = 4'd0; i_pe_finish = 1'b1;
      cyc();
      i_start = 1'b0; i_pe_finish = 1'b0;
      chk("same_cycle_overrun", int'(o_overrun), 1);
      chk("same_cycle_busy", int'(o_busy), 1);
      chk("same_cycle_no_drain", int'(o_valid), 0);
      push_tile();
      pulse();
      chk("np0_valid", int'(o_valid), 1);
      chk("np0_idx", int'(o_idx), 0);
      wait_done(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
